// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the instruction
// cache and the data cache, and routes returning load data back to the cache
// that issued the load.
//
// The data cache wins arbitration by default. The icache is forced to win
// once it has lost STARVE_LIMIT cycles in a row.
//
// Ports:
//   clock, reset                  clock; asynchronous active-low reset
//   icache_command/addr           icache request (loads only)
//   dcache_command/addr/wdata     dcache request (load or store)
//   mem2proc_transaction_tag      memory accept tag for this cycle (0 = rejected)
//   mem2proc_data/data_tag        returning load data and its tag (0 = none)
//   proc2mem_command/addr/data    forwarded request to memory
//   icache_grant, dcache_grant    port owner this cycle
//   *_transaction_tag             accept tag, passed only to the granted cache
//   *_data, *_data_tag            load data routed to the owning cache
//   busy                          at least one load tag is outstanding
//   orphan_response               nonzero data tag arrived with no owner

package mem_arbiter_pkg;
    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;
    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  MEM_COMMAND icache_command,
    input  ADDR        icache_addr,
    input  MEM_COMMAND dcache_command,
    input  ADDR        dcache_addr,
    input  MEM_BLOCK   dcache_wdata,
    input  MEM_TAG     mem2proc_transaction_tag,
    input  MEM_BLOCK   mem2proc_data,
    input  MEM_TAG     mem2proc_data_tag,
    output MEM_COMMAND proc2mem_command,
    output ADDR        proc2mem_addr,
    output MEM_BLOCK   proc2mem_data,
    output logic       icache_grant,
    output logic       dcache_grant,
    output MEM_TAG     icache_transaction_tag,
    output MEM_TAG     dcache_transaction_tag,
    output MEM_BLOCK   icache_data,
    output MEM_BLOCK   dcache_data,
    output MEM_TAG     icache_data_tag,
    output MEM_TAG     dcache_data_tag,
    output logic       busy,
    output logic       orphan_response
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          icache_req;
    logic          dcache_req;
    logic          starved;

    // Ownership table indexed by tag; entry 0 is never allocated because
    // tag 0 means "no tag", so valid[0] stays 0.
    logic [15:0]   tag_valid;
    logic [15:0]   tag_owner;   // 0 = icache, 1 = dcache
    logic          alloc_en;
    logic          resp_hit;
    logic          resp_owner;

    // Arbitration
    always_comb begin
        icache_req   = (icache_command != MEM_NONE);
        dcache_req   = (dcache_command != MEM_NONE);
        starved      = (starve_cnt == CW'(STARVE_LIMIT));
        icache_grant = icache_req && (!dcache_req || starved);
        dcache_grant = dcache_req && !icache_grant;
    end

    // Forwarding and accept-tag passthrough
    always_comb begin
        proc2mem_command       = MEM_NONE;
        proc2mem_addr          = '0;
        proc2mem_data          = '0;
        icache_transaction_tag = '0;
        dcache_transaction_tag = '0;
        if (icache_grant) begin
            proc2mem_command       = icache_command;
            proc2mem_addr          = icache_addr;
            icache_transaction_tag = mem2proc_transaction_tag;
        end else if (dcache_grant) begin
            proc2mem_command       = dcache_command;
            proc2mem_addr          = dcache_addr;
            proc2mem_data          = dcache_wdata;
            dcache_transaction_tag = mem2proc_transaction_tag;
        end
    end

    // Response routing from the registered table
    always_comb begin
        alloc_en        = (proc2mem_command == MEM_LOAD) && (mem2proc_transaction_tag != '0);
        resp_hit        = (mem2proc_data_tag != '0) && tag_valid[mem2proc_data_tag];
        resp_owner      = tag_owner[mem2proc_data_tag];
        orphan_response = (mem2proc_data_tag != '0) && !tag_valid[mem2proc_data_tag];
        icache_data     = '0;
        icache_data_tag = '0;
        dcache_data     = '0;
        dcache_data_tag = '0;
        if (resp_hit) begin
            if (resp_owner) begin
                dcache_data     = mem2proc_data;
                dcache_data_tag = mem2proc_data_tag;
            end else begin
                icache_data     = mem2proc_data;
                icache_data_tag = mem2proc_data_tag;
            end
        end
        busy = |tag_valid;
    end

    // Anti-starvation counter: consecutive cycles the icache requested and lost
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (icache_req && !icache_grant) begin
            if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Ownership table. The allocate is written after the clear so that a
    // same-tag allocate and response in one cycle leaves the entry allocated.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            if (resp_hit) begin
                tag_valid[mem2proc_data_tag] <= 1'b0;
            end
            if (alloc_en) begin
                tag_valid[mem2proc_transaction_tag] <= 1'b1;
                tag_owner[mem2proc_transaction_tag] <= dcache_grant;
            end
        end
    end

endmodule
